// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, command encodings, collector states and operand-need decode.
package alu_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int CMD_WIDTH = 4;
  localparam logic [CMD_WIDTH-1:0] CMD_INC_A = 4;
  localparam logic [CMD_WIDTH-1:0] CMD_DEC_A = 5;
  localparam logic [CMD_WIDTH-1:0] CMD_INC_B = 6;
  localparam logic [CMD_WIDTH-1:0] CMD_DEC_B = 7;
  localparam logic [CMD_WIDTH-1:0] CMD_NOT_A = 6;
  localparam logic [CMD_WIDTH-1:0] CMD_NOT_B = 7;
  localparam logic [CMD_WIDTH-1:0] CMD_SHR1_A = 8;
  localparam logic [CMD_WIDTH-1:0] CMD_SHL1_A = 9;
  localparam logic [CMD_WIDTH-1:0] CMD_SHR1_B = 10;
  localparam logic [CMD_WIDTH-1:0] CMD_SHL1_B = 11;
  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B, ISSUE} opc_state_e;
  typedef enum logic [1:0] {NEED_BOTH, NEED_A, NEED_B} op_need_e;
  function automatic op_need_e op_need(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
    if (mode)
      return (cmd == CMD_INC_A || cmd == CMD_DEC_A) ? NEED_A :
             (cmd == CMD_INC_B || cmd == CMD_DEC_B) ? NEED_B : NEED_BOTH;
    return (cmd == CMD_NOT_A || cmd == CMD_SHR1_A || cmd == CMD_SHL1_A) ? NEED_A :
           (cmd == CMD_NOT_B || cmd == CMD_SHR1_B || cmd == CMD_SHL1_B) ? NEED_B : NEED_BOTH;
  endfunction
endpackage

// File: rtl/alu_opc_timer.sv
// alu_opc_timer: wait-cycle counter; expire flags the final allowed wait cycle.
module alu_opc_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  assign expire = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: gathers split OPA/OPB beats and issues one complete op over valid/ready.
// Define ALU_OPC_CMD_CHECK_EN to drop completions whose cmd/mode differ from the first beat.
module alu_operand_collector
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int CMD_WIDTH = alu_pkg::CMD_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [1:0]            inp_valid,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  input  logic                  cin,
  input  logic                  mode,
  input  logic [CMD_WIDTH-1:0]  cmd,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_opa,
  output logic [DATA_WIDTH-1:0] out_opb,
  output logic                  out_cin,
  output logic                  out_mode,
  output logic [CMD_WIDTH-1:0]  out_cmd,
  output logic [1:0]            out_present,
  output logic                  timeout_err,
  output logic                  cmd_mismatch
);
  opc_state_e state, state_nx;
  op_need_e need;
  logic beat, xfer, full, waiting, fill, fresh, mism, expire, tmo;
  assign in_ready = ce && state != ISSUE;
  assign out_valid = state == ISSUE;
  assign beat = in_ready && inp_valid != 2'b00;
  assign xfer = ce && out_valid && out_ready;
  assign need = op_need(mode, cmd);
  assign full = inp_valid == 2'b11 || (need == NEED_A && inp_valid[0]) || (need == NEED_B && inp_valid[1]);
  assign waiting = state == WAIT_A || state == WAIT_B;
  // fresh latches a whole new op (idle beat, or 11 replacing a partial); fill supplies the missing half
  assign fresh = beat && (state == IDLE || inp_valid == 2'b11);
  assign fill = beat && ((state == WAIT_A && inp_valid == 2'b01) || (state == WAIT_B && inp_valid == 2'b10));
`ifdef ALU_OPC_CMD_CHECK_EN
  assign mism = fill && (cmd != out_cmd || mode != out_mode);
`else
  assign mism = 1'b0;
`endif
  assign tmo = waiting && ce && expire && !fill && !fresh;
  alu_opc_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .clr(!waiting),
    .en(ce && waiting),
    .expire(expire)
  );
  always_comb begin
    state_nx = state;
    if (fresh) state_nx = full ? ISSUE : inp_valid[0] ? WAIT_B : WAIT_A;
    else if (fill) state_nx = mism ? IDLE : ISSUE;
    else if (tmo || xfer) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      out_opa <= '0;
      out_opb <= '0;
      out_cin <= 1'b0;
      out_mode <= 1'b0;
      out_cmd <= '0;
      out_present <= 2'b00;
      timeout_err <= 1'b0;
      cmd_mismatch <= 1'b0;
    end else begin
      state <= state_nx;
      timeout_err <= tmo;
      cmd_mismatch <= mism;
      if (fresh) begin
        out_opa <= inp_valid[0] ? opa : '0;
        out_opb <= inp_valid[1] ? opb : '0;
        out_cin <= cin;
        out_mode <= mode;
        out_cmd <= cmd;
        out_present <= inp_valid;
      end else if (beat) begin
        if (inp_valid[0]) out_opa <= opa;
        if (inp_valid[1]) out_opb <= opb;
        out_present <= out_present | inp_valid;
      end
    end
endmodule

// File: tb/tb_alu_operand_collector.sv
// tb_alu_operand_collector: directed scenarios plus random beats checked against a behavioural model.
module tb_alu_operand_collector;
  localparam int T = 16;
`ifdef ALU_OPC_CMD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, ce = 1'b0, cin = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [1:0] inp_valid = 2'b00;
  logic [7:0] opa = 8'h00, opb = 8'h00;
  logic [3:0] cmd = 4'h0;
  logic in_ready, out_valid, out_cin, out_mode, timeout_err, cmd_mismatch;
  logic [7:0] out_opa, out_opb;
  logic [3:0] out_cmd;
  logic [1:0] out_present;
  int errors = 0, checks = 0;

  alu_operand_collector #(.DATA_WIDTH(8), .CMD_WIDTH(4), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .ce(ce), .inp_valid(inp_valid), .opa(opa), .opb(opb),
    .cin(cin), .mode(mode), .cmd(cmd), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_opa(out_opa), .out_opb(out_opb), .out_cin(out_cin),
    .out_mode(out_mode), .out_cmd(out_cmd), .out_present(out_present),
    .timeout_err(timeout_err), .cmd_mismatch(cmd_mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural model: a held operation that is either partial or issuing, plus a wait count.
  bit m_iss = 0, m_part = 0, m_tmo = 0, m_mis = 0;
  int m_waits = 0;
  logic [7:0] ha = 0, hb = 0;
  logic [1:0] hp = 0;
  logic hc = 0, hmd = 0;
  logic [3:0] hcm = 0;

  function automatic int need_of(input logic md, input logic [3:0] c);
    if (md) return (c == 4 || c == 5) ? 1 : (c == 6 || c == 7) ? 2 : 0;
    return (c == 6 || c == 8 || c == 9) ? 1 : (c == 7 || c == 10 || c == 11) ? 2 : 0;
  endfunction

  function automatic bit sat(input int n, input logic [1:0] p);
    return n == 0 ? p == 2'b11 : n == 1 ? p[0] : p[1];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_iss = 0; m_part = 0; m_tmo = 0; m_mis = 0; m_waits = 0;
      ha = 0; hb = 0; hp = 0; hc = 0; hmd = 0; hcm = 0;
    end else begin
      m_tmo = 0;
      m_mis = 0;
      if (ce) begin
        if (m_iss) begin
          if (out_ready) m_iss = 0;
        end else if (inp_valid != 0 && (!m_part || inp_valid == 2'b11)) begin
          ha = inp_valid[0] ? opa : 8'h00;
          hb = inp_valid[1] ? opb : 8'h00;
          hp = inp_valid; hc = cin; hmd = mode; hcm = cmd;
          if (sat(need_of(mode, cmd), inp_valid)) begin
            m_iss = 1; m_part = 0;
          end else begin
            m_part = 1; m_waits = 0;
          end
        end else if (m_part) begin
          m_waits++;
          if (inp_valid != 0 && (inp_valid & hp) == 0) begin
            m_part = 0;
            if (CHK && (cmd != hcm || mode != hmd)) m_mis = 1;
            else begin
              if (inp_valid[0]) ha = opa;
              if (inp_valid[1]) hb = opb;
              hp = 2'b11;
              m_iss = 1;
            end
          end else begin
            if (inp_valid[0]) ha = opa;
            if (inp_valid[1]) hb = opb;
            if (m_waits == T) begin
              m_part = 0; m_tmo = 1;
            end
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_iss));
    check("in_ready", 32'(in_ready), 32'(ce && !m_iss));
    check("timeout_err", 32'(timeout_err), 32'(m_tmo));
    check("cmd_mismatch", 32'(cmd_mismatch), 32'(m_mis));
    if (m_iss) begin
      check("out_opa", 32'(out_opa), 32'(ha));
      check("out_opb", 32'(out_opb), 32'(hb));
      check("out_cin", 32'(out_cin), 32'(hc));
      check("out_mode", 32'(out_mode), 32'(hmd));
      check("out_cmd", 32'(out_cmd), 32'(hcm));
      check("out_present", 32'(out_present), 32'(hp));
    end
  endtask

  task automatic cyc(input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic md, input logic [3:0] cm, input logic e, input logic r);
    inp_valid = iv; opa = a; opb = b; cin = c; mode = md; cmd = cm; ce = e; out_ready = r;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
  endtask

  initial begin
    ce = 1'b1;
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst out_present", 32'(out_present), 0);
    check("rst out_opa", 32'(out_opa), 0);
    check("rst out_cmd", 32'(out_cmd), 0);
    check("rst timeout_err", 32'(timeout_err), 0);
    check("rst in_ready", 32'(in_ready), 1);
    ce = 1'b0;
    #1 check("rst in_ready ce0", 32'(in_ready), 0);
    ce = 1'b1;
    @(negedge clk) reset = 1'b1;
    // both operands in one beat
    cyc(2'b11, 8'h12, 8'h34, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    check("t1 out_valid", 32'(out_valid), 1);
    check("t1 out_present", 32'(out_present), 3);
    check("t1 out_opa", 32'(out_opa), 32'h12);
    check("t1 out_opb", 32'(out_opb), 32'h34);
    check("t1 model issuing", 32'(m_iss), 1);
    idle();
    check("t1 done", 32'(out_valid), 0);
    // single-operand command issues at once
    cyc(2'b01, 8'hFF, 8'hAB, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
    check("t2 out_valid", 32'(out_valid), 1);
    check("t2 out_present", 32'(out_present), 1);
    check("t2 out_opb", 32'(out_opb), 0);
    check("t2 out_opa", 32'(out_opa), 32'hFF);
    idle();
    // completion on the final wait cycle beats the timeout
    cyc(2'b10, 8'h00, 8'h05, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    repeat (T - 1) idle();
    check("t3 still waiting", 32'(out_valid), 0);
    cyc(2'b01, 8'h03, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    check("t3 out_valid", 32'(out_valid), 1);
    check("t3 timeout_err", 32'(timeout_err), 0);
    check("t3 out_opa", 32'(out_opa), 3);
    check("t3 out_opb", 32'(out_opb), 5);
    check("t3 model waits", 32'(m_waits), T);
    idle();
    // timeout after T empty wait cycles
    cyc(2'b01, 8'h11, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    repeat (T - 1) idle();
    check("t4 no early timeout", 32'(timeout_err), 0);
    idle();
    check("t4 timeout_err", 32'(timeout_err), 1);
    check("t4 out_valid", 32'(out_valid), 0);
    check("t4 model tmo", 32'(m_tmo), 1);
    idle();
    check("t4 pulse clears", 32'(timeout_err), 0);
    check("t4 in_ready", 32'(in_ready), 1);
    // ce low freezes the timer
    cyc(2'b01, 8'h07, 8'h00, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
    repeat (40) cyc(2'b11, 8'hEE, 8'hDD, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1);
    check("t5 timeout_err", 32'(timeout_err), 0);
    check("t5 out_valid", 32'(out_valid), 0);
    cyc(2'b10, 8'h00, 8'h09, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    check("t5 out_valid", 32'(out_valid), 1);
    check("t5 out_cin", 32'(out_cin), 1);
    check("t5 out_opa", 32'(out_opa), 7);
    check("t5 out_opb", 32'(out_opb), 9);
    idle();
    // backpressure holds the output
    cyc(2'b11, 8'hAA, 8'h55, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(2'b11, 8'h01, 8'h02, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
      check("t6 out_opa held", 32'(out_opa), 32'hAA);
      check("t6 out_opb held", 32'(out_opb), 32'h55);
      check("t6 in_ready", 32'(in_ready), 0);
    end
    idle();
    check("t6 released", 32'(out_valid), 0);
`ifdef ALU_OPC_CMD_CHECK_EN
    cyc(2'b01, 8'h10, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    cyc(2'b10, 8'h00, 8'h20, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1);
    check("t6 cmd_mismatch", 32'(cmd_mismatch), 1);
    check("t6 mismatch dropped", 32'(out_valid), 0);
    idle();
    check("t6 mismatch clears", 32'(cmd_mismatch), 0);
`endif
    // asynchronous reset mid-partial and mid-issue
    cyc(2'b01, 8'h33, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    check("r1 partial present", 32'(out_present), 1);
    #2 reset = 1'b0;
    #1 check("r1 out_present", 32'(out_present), 0);
    check("r1 out_opa", 32'(out_opa), 0);
    @(negedge clk) reset = 1'b1;
    idle();
    cyc(2'b11, 8'h44, 8'h66, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 check("r2 out_valid", 32'(out_valid), 0);
    @(negedge clk) reset = 1'b1;
    idle();
    // random traffic with periodic quiet stretches so partials time out
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 < 20) idle();
      else begin
        int r;
        r = $urandom_range(0, 4);
        cyc(r < 2 ? 2'b00 : 2'(r - 1), 8'($urandom), 8'($urandom), 1'($urandom),
            1'($urandom), 4'($urandom_range(0, 11)), $urandom_range(0, 9) != 0, 1'($urandom));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
